// File: rtl/mul_div_unit_pkg.sv
// Shared opcode header: ALU and multiply/divide funct codes plus the
// multiply/divide unit's operation and state encodings.
package mul_div_unit_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_XOR   = 6'b100110;
   localparam logic [5:0] FUNCT_NOR   = 6'b100111;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } md_state_e;

   localparam logic [5:0] ITER_LAST = 6'd31;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (md_op_e'(op) == OP_MULT) || (md_op_e'(op) == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (md_op_e'(op) == OP_DIV) || (md_op_e'(op) == OP_DIVU);
   endfunction

endpackage

// File: rtl/mul_div_unit_cond_negate32.sv
// 32-bit conditional two's-complement negator; cin lets two instances
// chain into a 64-bit negation (high half adds 1 only if low half is zero).
module cond_negate32 (
   input  logic [31:0] x,
   input  logic        neg,
   input  logic        cin,
   output logic [31:0] y
);

   always_comb begin
      y = x;
      if (neg) y = ~x + {31'b0, cin};
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers:
// shift-add multiply and restoring divide over one shared adder.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             MtHi,
   input  logic             MtLo,
   input  logic             Flush,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             Done
);

   md_state_e   state, state_nxt;
   logic [5:0]  count;
   logic        is_div, neg_q, neg_r, div_zero;
   logic [31:0] acc, shreg, divisor;
   logic [31:0] a_abs, b_abs, hi_fix, lo_fix;
   logic        signed_op, start_ok, moves_ok;
   logic [32:0] add_a, mul_sum;
   logic [33:0] add_y;

   assign signed_op = op_is_signed(Op);
   assign start_ok  = (state == S_IDLE) && Start && !Flush;
   assign moves_ok  = (state == S_IDLE) && !Start && !Flush;

   cond_negate32 u_abs_a (.x(A), .neg(signed_op & A[31]), .cin(1'b1), .y(a_abs));
   cond_negate32 u_abs_b (.x(B), .neg(signed_op & B[31]), .cin(1'b1), .y(b_abs));

   // LO always carries the quotient/low product; HI chains off LO for a
   // 64-bit product negation, otherwise it is the remainder.
   cond_negate32 u_fix_lo (.x(shreg), .neg(neg_q), .cin(1'b1), .y(lo_fix));
   cond_negate32 u_fix_hi (
      .x   (acc),
      .neg (is_div ? neg_r : neg_q),
      .cin (is_div ? 1'b1 : (shreg == '0)),
      .y   (hi_fix)
   );

   // Shared adder: add for multiply, subtract the divisor from the shifted
   // partial remainder for divide (bit 33 is the borrow).
   always_comb begin
      add_a   = is_div ? {acc, shreg[31]} : {1'b0, acc};
      add_y   = {1'b0, add_a} + ({34{is_div}} ^ {2'b00, divisor}) + {33'b0, is_div};
      mul_sum = shreg[0] ? add_y[32:0] : {1'b0, acc};
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      Busy      = 1'b0;
      case (state)
         S_IDLE: if (Start) state_nxt = S_RUN;
         S_RUN: begin
            Busy = 1'b1;
            if (count == ITER_LAST) state_nxt = S_FIX;
         end
         S_FIX: begin
            Busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (Flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         count    <= '0;
         acc      <= '0;
         shreg    <= '0;
         divisor  <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         HI       <= '0;
         LO       <= '0;
         Done     <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  count    <= '0;
                  acc      <= '0;
                  shreg    <= a_abs;
                  divisor  <= b_abs;
                  is_div   <= op_is_div(Op);
                  neg_q    <= signed_op & (A[31] ^ B[31]);
                  neg_r    <= signed_op & A[31];
                  div_zero <= op_is_div(Op) && (B == '0);
               end else if (moves_ok) begin
                  if (MtHi) HI <= A;
                  if (MtLo) LO <= A;
               end
            end
            S_RUN: begin
               count <= count + 6'd1;
               if (is_div) begin
                  if (add_y[33]) begin
                     acc   <= add_a[31:0];
                     shreg <= {shreg[30:0], 1'b0};
                  end else begin
                     acc   <= add_y[31:0];
                     shreg <= {shreg[30:0], 1'b1};
                  end
               end else begin
                  acc   <= mul_sum[32:1];
                  shreg <= {mul_sum[0], shreg[31:1]};
               end
            end
            S_FIX: begin
               // Divide by zero: remainder path already yields A; force LO.
               if (!Flush) begin
                  HI   <= hi_fix;
                  LO   <= div_zero ? '1 : lo_fix;
                  Done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model checked every
// cycle, plus hand-computed literal results, latencies and control cases.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        Clock = 1'b0, Reset_n = 1'b0, Start = 1'b0;
   logic        MtHi = 1'b0, MtLo = 1'b0, Flush = 1'b0;
   logic [1:0]  Op = 2'd0;
   logic [31:0] A = '0, B = '0;
   logic [31:0] HI, LO;
   logic        Busy, Done;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   always #5 Clock = ~Clock;

   mul_div_unit #(.WIDTH(32)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
      .MtHi(MtHi), .MtLo(MtLo), .Flush(Flush), .HI(HI), .LO(LO),
      .Busy(Busy), .Done(Done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference results straight from integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: begin p = sa * sb; return p; end
         2'd1: return {32'b0, a} * {32'b0, b};
         2'd2: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   logic [63:0] c_res;
   assign c_res = ref_result(Op, A, B);

   // Timing model: an accepted Start makes the unit busy for 33 cycles,
   // results and Done appear on the edge that ends the busy window.
   int          m_rem = 0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_done = 1'b0;

   always @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         m_rem  <= 0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (Flush) m_rem <= 0;
         else if (m_rem == 0) begin
            if (Start) begin
               m_rem <= 33;
               {p_hi, p_lo} <= c_res;
            end else begin
               if (MtHi) m_hi <= A;
               if (MtLo) m_lo <= A;
            end
         end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_hi   <= p_hi;
               m_lo   <= p_lo;
               m_done <= 1'b1;
            end
         end
      end
   end

   always @(negedge Clock) begin
      if (mon_en) begin
         chk("mon_busy", {31'b0, Busy}, {31'b0, (m_rem != 0)});
         chk("mon_done", {31'b0, Done}, {31'b0, m_done});
         chk("mon_hi", HI, m_hi);
         chk("mon_lo", LO, m_lo);
      end
   end

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int restart_at, input bit with_move);
      bit got;
      got = 1'b0;
      @(posedge Clock); #1;
      Start = 1'b1; Op = op; A = a; B = b; MtHi = with_move; MtLo = with_move;
      for (int lat = 1; lat <= 40 && !got; lat++) begin
         @(posedge Clock); #1;
         Start = (lat == restart_at);
         MtHi  = (lat == restart_at);
         MtLo  = (lat == restart_at);
         if (lat == restart_at) begin
            Op = OP_MULTU; A = 32'h9; B = 32'h9;
         end
         if (Done) begin
            got = 1'b1;
            chk({name, " latency"}, 32'(lat), 32'd34);
            chk({name, " busy_end"}, {31'b0, Busy}, 32'd0);
         end else begin
            chk({name, " busy"}, {31'b0, Busy}, 32'd1);
         end
      end
      if (!got) chk({name, " done_timeout"}, {31'b0, Done}, 32'd1);
      @(posedge Clock); #1;
      chk({name, " done_pulse"}, {31'b0, Done}, 32'd0);
      chk({name, " hi"}, HI, exp_hi);
      chk({name, " lo"}, LO, exp_lo);
   endtask

   task automatic move(input bit hi, input bit lo, input logic [31:0] val,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      @(posedge Clock); #1;
      MtHi = hi; MtLo = lo; A = val;
      @(posedge Clock); #1;
      MtHi = 1'b0; MtLo = 1'b0;
      chk("move hi", HI, exp_hi);
      chk("move lo", LO, exp_lo);
   endtask

   task automatic no_done(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge Clock); #1;
         chk({name, " no_done"}, {31'b0, Done}, 32'd0);
      end
   endtask

   task automatic flush_op(input string name, input int flush_at,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      @(posedge Clock); #1;
      Start = 1'b1; Op = OP_MULTU; A = 32'd5; B = 32'd6;
      for (int lat = 1; lat <= flush_at + 1; lat++) begin
         @(posedge Clock); #1;
         Start = 1'b0;
         Flush = (lat == flush_at);
         if (lat == flush_at + 1) begin
            chk({name, " busy_after"}, {31'b0, Busy}, 32'd0);
            chk({name, " done_after"}, {31'b0, Done}, 32'd0);
         end
      end
      no_done(name, 40);
      chk({name, " hi"}, HI, exp_hi);
      chk({name, " lo"}, LO, exp_lo);
   endtask

   initial begin
      repeat (3) @(posedge Clock);
      #1;
      chk("rst hi", HI, 32'd0);
      chk("rst lo", LO, 32'd0);
      chk("rst busy", {31'b0, Busy}, 32'd0);
      chk("rst done", {31'b0, Done}, 32'd0);
      Reset_n = 1'b1;
      mon_en  = 1'b1;

      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
      run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0);
      run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
      run_op("divu_zero", OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 0, 0);
      run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0);
      run_op("divu_100_7",OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       0, 0);
      run_op("mult_7_m2", OP_MULT,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 0, 0);
      run_op("div_7_m2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 0);
      run_op("div_zero",  OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, 0);
      run_op("multu_sh",  OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 0, 0);
      run_op("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0);
      run_op("mult_zero", OP_MULT,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0);

      move(1'b1, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000);
      move(1'b0, 1'b1, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D);
      move(1'b1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
      move(1'b1, 1'b0, 32'h12345678, 32'h12345678, 32'hA5A5A5A5);

      flush_op("flush10", 10, 32'h12345678, 32'hA5A5A5A5);

      run_op("restart5",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       5, 0);
      run_op("start_mv",  OP_MULTU, 32'd3,        32'd4,        32'd0,        32'd12,       0, 1);

      // Flush and Start together in IDLE: nothing starts.
      @(posedge Clock); #1;
      Start = 1'b1; Flush = 1'b1; Op = OP_MULTU; A = 32'd5; B = 32'd6;
      @(posedge Clock); #1;
      Start = 1'b0; Flush = 1'b0;
      chk("flush_start busy", {31'b0, Busy}, 32'd0);
      no_done("flush_start", 40);

      flush_op("flush33", 33, 32'd0, 32'd12);

      // Reset in the middle of a run.
      @(posedge Clock); #1;
      Start = 1'b1; Op = OP_MULTU; A = 32'd5; B = 32'd6;
      for (int lat = 1; lat <= 20; lat++) begin
         @(posedge Clock); #1;
         Start = 1'b0;
      end
      Reset_n = 1'b0;
      #1;
      chk("reset20 hi", HI, 32'd0);
      chk("reset20 lo", LO, 32'd0);
      chk("reset20 busy", {31'b0, Busy}, 32'd0);
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clock); #1;
         chk("reset20 no_done", {31'b0, Done}, 32'd0);
         chk("reset20 idle", {31'b0, Busy}, 32'd0);
      end

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
